ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 147 ++++++++++++++
 tb/tb_ex_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with logic/shift/move ops, HI/LO registers and a
// 32-step sequential shift-add multiplier that stalls the pipeline while busy.
`ifndef EX_STAGE_DEFS
`define EX_STAGE_DEFS
`define RegBus        31:0
`define RegAddrBus    4:0
`define AluOpBus      7:0
`define AluSelBus     2:0
`define EXE_RES_NOP   3'b000
`define EXE_RES_LOGIC 3'b001
`define EXE_RES_SHIFT 3'b010
`define EXE_RES_MOVE  3'b011
`define EXE_NOP_OP    8'b00000000
`define EXE_AND_OP    8'b00100100
`define EXE_OR_OP     8'b00100101
`define EXE_XOR_OP    8'b00100110
`define EXE_NOR_OP    8'b00100111
`define EXE_SLL_OP    8'b01111100
`define EXE_SRL_OP    8'b00000010
`define EXE_SRA_OP    8'b00000011
`define EXE_MOVZ_OP   8'b00001010
`define EXE_MOVN_OP   8'b00001011
`define EXE_MFHI_OP   8'b00010000
`define EXE_MTHI_OP   8'b00010001
`define EXE_MFLO_OP   8'b00010010
`define EXE_MTLO_OP   8'b00010011
`define EXE_MULT_OP   8'b00011000
`define EXE_MULTU_OP  8'b00011001
`endif

module ex_stage (
    input  logic               clk,
    input  logic               rst,
    input  logic [`AluOpBus]   aluop_i,
    input  logic [`AluSelBus]  alusel_i,
    input  logic [`RegBus]     reg1_i,
    input  logic [`RegBus]     reg2_i,
    input  logic [`RegAddrBus] wd_i,
    input  logic               wreg_i,
    input  logic               valid_i,
    input  logic               stall_i,
    output logic [`RegAddrBus] wd_o,
    output logic               wreg_o,
    output logic [`RegBus]     wdata_o,
    output logic [`RegAddrBus] ex_wd_o,
    output logic               ex_wreg_o,
    output logic [`RegBus]     ex_wdata_o,
    output logic               stallreq_o,
    output logic [`RegBus]     hi_o,
    output logic [`RegBus]     lo_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_mcand, r_prod;
    logic [31:0] r_mplier, r_hi, r_lo;
    logic        r_neg;
    logic        w_known, w_mul, w_signed, w_mthi, w_mtlo, w_ok;
    logic [31:0] w_res, w_abs1, w_abs2;
    logic [63:0] w_final;

    always_comb begin
        w_res   = '0;
        w_known = 1'b1;
        case ({alusel_i, aluop_i})
            {`EXE_RES_LOGIC, `EXE_OR_OP}:   w_res = reg1_i | reg2_i;
            {`EXE_RES_LOGIC, `EXE_AND_OP}:  w_res = reg1_i & reg2_i;
            {`EXE_RES_LOGIC, `EXE_XOR_OP}:  w_res = reg1_i ^ reg2_i;
            {`EXE_RES_LOGIC, `EXE_NOR_OP}:  w_res = ~(reg1_i | reg2_i);
            {`EXE_RES_SHIFT, `EXE_SLL_OP}:  w_res = reg2_i << reg1_i[4:0];
            {`EXE_RES_SHIFT, `EXE_SRL_OP}:  w_res = reg2_i >> reg1_i[4:0];
            {`EXE_RES_SHIFT, `EXE_SRA_OP}:  w_res = $signed(reg2_i) >>> reg1_i[4:0];
            {`EXE_RES_MOVE,  `EXE_MOVZ_OP}: w_res = reg1_i;
            {`EXE_RES_MOVE,  `EXE_MOVN_OP}: w_res = reg1_i;
            {`EXE_RES_MOVE,  `EXE_MFHI_OP}: w_res = r_hi;
            {`EXE_RES_MOVE,  `EXE_MFLO_OP}: w_res = r_lo;
            {`EXE_RES_NOP,   `EXE_MTHI_OP}: ;
            {`EXE_RES_NOP,   `EXE_MTLO_OP}: ;
            {`EXE_RES_NOP,   `EXE_MULT_OP}: ;
            {`EXE_RES_NOP,   `EXE_MULTU_OP}: ;
            default:                        w_known = 1'b0;
        endcase
    end

    assign w_signed   = aluop_i == `EXE_MULT_OP;
    assign w_mul      = valid_i && alusel_i == `EXE_RES_NOP && (w_signed || aluop_i == `EXE_MULTU_OP);
    assign w_mthi     = valid_i && {alusel_i, aluop_i} == {`EXE_RES_NOP, `EXE_MTHI_OP};
    assign w_mtlo     = valid_i && {alusel_i, aluop_i} == {`EXE_RES_NOP, `EXE_MTLO_OP};
    assign w_abs1     = (w_signed && reg1_i[31]) ? -reg1_i : reg1_i;
    assign w_abs2     = (w_signed && reg2_i[31]) ? -reg2_i : reg2_i;
    assign w_final    = r_neg ? -r_prod : r_prod;
    // Multiply cycles (IDLE-with-mult, BUSY, DONE) all hand EX/MEM a bubble
    assign w_ok       = rst && valid_i && w_known && !w_mul && r_state == IDLE;
    assign ex_wd_o    = w_ok ? wd_i : '0;
    assign ex_wreg_o  = w_ok && wreg_i && !w_mthi && !w_mtlo;
    assign ex_wdata_o = w_ok ? w_res : '0;
    assign stallreq_o = rst && (r_state == BUSY || (r_state == IDLE && w_mul));
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_o     <= '0;
            wreg_o   <= 1'b0;
            wdata_o  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_neg    <= 1'b0;
        end else if (!stall_i) begin
            wd_o    <= ex_wd_o;
            wreg_o  <= ex_wreg_o;
            wdata_o <= ex_wdata_o;
            case (r_state)
                IDLE: begin
                    if (w_mul) begin
                        r_state  <= BUSY;
                        r_cnt    <= '0;
                        r_mcand  <= {32'd0, w_abs1};
                        r_mplier <= w_abs2;
                        r_prod   <= '0;
                        r_neg    <= w_signed && (reg1_i[31] ^ reg2_i[31]);
                    end else begin
                        if (w_mthi) r_hi <= reg1_i;
                        if (w_mtlo) r_lo <= reg1_i;
                    end
                end
                BUSY: begin
                    r_prod   <= r_prod + (r_mplier[0] ? r_mcand : 64'd0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= DONE;
                end
                DONE: begin
                    {r_hi, r_lo} <= w_final;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector self-checking bench for ex_stage.
`ifndef EX_STAGE_DEFS
`define EX_STAGE_DEFS
`define RegBus        31:0
`define RegAddrBus    4:0
`define AluOpBus      7:0
`define AluSelBus     2:0
`define EXE_RES_NOP   3'b000
`define EXE_RES_LOGIC 3'b001
`define EXE_RES_SHIFT 3'b010
`define EXE_RES_MOVE  3'b011
`define EXE_NOP_OP    8'b00000000
`define EXE_AND_OP    8'b00100100
`define EXE_OR_OP     8'b00100101
`define EXE_XOR_OP    8'b00100110
`define EXE_NOR_OP    8'b00100111
`define EXE_SLL_OP    8'b01111100
`define EXE_SRL_OP    8'b00000010
`define EXE_SRA_OP    8'b00000011
`define EXE_MOVZ_OP   8'b00001010
`define EXE_MOVN_OP   8'b00001011
`define EXE_MFHI_OP   8'b00010000
`define EXE_MTHI_OP   8'b00010001
`define EXE_MFLO_OP   8'b00010010
`define EXE_MTLO_OP   8'b00010011
`define EXE_MULT_OP   8'b00011000
`define EXE_MULTU_OP  8'b00011001
`endif

module tb_ex_stage;
    logic               clk = 1'b0;
    logic               rst;
    logic [`AluOpBus]   aluop_i;
    logic [`AluSelBus]  alusel_i;
    logic [`RegBus]     reg1_i, reg2_i;
    logic [`RegAddrBus] wd_i;
    logic               wreg_i, valid_i, stall_i;
    logic [`RegAddrBus] wd_o, ex_wd_o;
    logic               wreg_o, ex_wreg_o, stallreq_o;
    logic [`RegBus]     wdata_o, ex_wdata_o, hi_o, lo_o;
    int                 n_chk = 0;
    int                 n_err = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .valid_i(valid_i), .stall_i(stall_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o),
        .ex_wdata_o(ex_wdata_o), .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr, input logic v);
        alusel_i = sel; aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr; valid_i = v;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each falling edge
    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    task automatic bubble;
        drive(`EXE_RES_NOP, `EXE_NOP_OP, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic run_mul(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int stall_at, input int exp_n,
                           input logic [63:0] exp);
        int   n;
        logic seen;
        drive(`EXE_RES_NOP, op, a, b, 5'd9, 1'b1, 1'b1);
        #1;
        n    = 0;
        seen = ex_wreg_o;
        while (stallreq_o && n < 100) begin
            n++;
            if (n == stall_at) stall_i = 1'b1;
            if (n == stall_at + 5) stall_i = 1'b0;
            cyc;
            seen |= ex_wreg_o | wreg_o;
        end
        stall_i = 1'b0;
        check({tag, "_stall_cycles"}, 64'(n), 64'(exp_n));
        cyc;
        check({tag, "_hilo"}, {hi_o, lo_o}, exp);
        check({tag, "_no_wreg"}, 64'(seen), 64'd0);
    endtask

    initial begin
        rst     = 1'b0;
        stall_i = 1'b0;
        bubble;
        #1;
        check("rst_wreg", 64'(wreg_o), 0);
        check("rst_wdata", 64'(wdata_o), 0);
        check("rst_hilo", {hi_o, lo_o}, 0);
        check("rst_stallreq", 64'(stallreq_o), 0);
        cyc;
        rst = 1'b1;

        drive(`EXE_RES_LOGIC, `EXE_OR_OP, 32'h0000_FF00, 32'h0F0F_0000, 5'd3, 1'b1, 1'b1);
        #1;
        check("or_ex_wdata", 64'(ex_wdata_o), 64'h0F0F_FF00);
        check("or_ex_wreg", 64'(ex_wreg_o), 1);
        check("or_ex_wd", 64'(ex_wd_o), 3);
        cyc;
        check("or_wdata", 64'(wdata_o), 64'h0F0F_FF00);
        check("or_wd", 64'(wd_o), 3);
        check("or_wreg", 64'(wreg_o), 1);

        stall_i = 1'b1;
        drive(`EXE_RES_LOGIC, `EXE_XOR_OP, 32'hF0F0_1234, 32'hFF00_FF00, 5'd4, 1'b1, 1'b1);
        cyc;
        check("stall_hold_wdata", 64'(wdata_o), 64'h0F0F_FF00);
        check("stall_xor_ex", 64'(ex_wdata_o), 64'h0FF0_ED34);
        stall_i = 1'b0;
        drive(`EXE_RES_LOGIC, `EXE_AND_OP, 32'hF0F0_1234, 32'hFF00_FF00, 5'd4, 1'b1, 1'b1);
        #1;
        check("and_ex", 64'(ex_wdata_o), 64'hF000_1200);
        drive(`EXE_RES_LOGIC, `EXE_NOR_OP, 32'hF0F0_1234, 32'hFF00_FF00, 5'd4, 1'b1, 1'b1);
        #1;
        check("nor_ex", 64'(ex_wdata_o), 64'h000F_00CB);

        drive(`EXE_RES_SHIFT, `EXE_SRA_OP, 32'd4, 32'h8000_0000, 5'd5, 1'b1, 1'b1);
        cyc;
        check("sra_wdata", 64'(wdata_o), 64'hF800_0000);
        drive(`EXE_RES_SHIFT, `EXE_SRL_OP, 32'd4, 32'h8000_0000, 5'd5, 1'b1, 1'b1);
        cyc;
        check("srl_wdata", 64'(wdata_o), 64'h0800_0000);
        drive(`EXE_RES_SHIFT, `EXE_SLL_OP, 32'hFFFF_FFE4, 32'h0000_0003, 5'd5, 1'b1, 1'b1);
        #1;
        check("sll_ex", 64'(ex_wdata_o), 64'h0000_0030);

        drive(`EXE_RES_LOGIC, `EXE_OR_OP, 32'h1111_1111, 32'h2222_2222, 5'd6, 1'b1, 1'b0);
        #1;
        check("bubble_ex_wreg", 64'(ex_wreg_o), 0);
        check("bubble_ex_wdata", 64'(ex_wdata_o), 0);
        cyc;
        check("bubble_wreg", 64'(wreg_o), 0);
        drive(`EXE_RES_LOGIC, `EXE_SLL_OP, 32'h1111_1111, 32'h2222_2222, 5'd6, 1'b1, 1'b1);
        #1;
        check("unknown_ex_wdata", 64'(ex_wdata_o), 0);
        check("unknown_ex_wreg", 64'(ex_wreg_o), 0);
        drive(`EXE_RES_MOVE, `EXE_MOVZ_OP, 32'hDEAD_BEEF, 32'd0, 5'd8, 1'b0, 1'b1);
        #1;
        check("movz_ex_wdata", 64'(ex_wdata_o), 64'hDEAD_BEEF);
        check("movz_ex_wreg", 64'(ex_wreg_o), 0);

        drive(`EXE_RES_NOP, `EXE_MTHI_OP, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 1'b1);
        #1;
        check("mthi_ex_wreg", 64'(ex_wreg_o), 0);
        cyc;
        check("mthi_wreg", 64'(wreg_o), 0);
        check("mthi_hi", 64'(hi_o), 64'h1234_5678);
        drive(`EXE_RES_MOVE, `EXE_MFHI_OP, 32'd0, 32'd0, 5'd7, 1'b1, 1'b1);
        #1;
        check("mfhi_ex_wdata", 64'(ex_wdata_o), 64'h1234_5678);
        cyc;
        check("mfhi_wdata", 64'(wdata_o), 64'h1234_5678);
        check("mfhi_wd", 64'(wd_o), 7);
        check("mfhi_wreg", 64'(wreg_o), 1);
        drive(`EXE_RES_NOP, `EXE_MTLO_OP, 32'hAABB_CCDD, 32'd0, 5'd5, 1'b1, 1'b1);
        cyc;
        check("mtlo_lo", 64'(lo_o), 64'hAABB_CCDD);
        check("mtlo_hi_kept", 64'(hi_o), 64'h1234_5678);
        drive(`EXE_RES_MOVE, `EXE_MFLO_OP, 32'd0, 32'd0, 5'd2, 1'b1, 1'b1);
        #1;
        check("mflo_ex_wdata", 64'(ex_wdata_o), 64'hAABB_CCDD);
        bubble;
        cyc;

        run_mul("mult_neg", `EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3, 0, 33, 64'hFFFF_FFFF_FFFF_FFFA);
        drive(`EXE_RES_MOVE, `EXE_MFHI_OP, 32'd0, 32'd0, 5'd2, 1'b1, 1'b1);
        #1;
        check("mfhi_after_mult", 64'(ex_wdata_o), 64'hFFFF_FFFF);
        bubble;
        cyc;
        run_mul("mult_mixed", `EXE_MULT_OP, 32'd7, 32'hFFFF_FFFB, 0, 33, 64'hFFFF_FFFF_FFFF_FFDD);
        bubble;
        cyc;
        run_mul("mult_min", `EXE_MULT_OP, 32'h8000_0000, 32'h8000_0000, 0, 33, 64'h4000_0000_0000_0000);
        bubble;
        cyc;
        run_mul("multu_stall", `EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, 12, 38, 64'h0000_0001_FFFF_FFFE);
        bubble;
        cyc;

        drive(`EXE_RES_NOP, `EXE_MULTU_OP, 32'd5, 32'd6, 5'd9, 1'b1, 1'b1);
        repeat (11) cyc;
        check("busy_stallreq", 64'(stallreq_o), 1);
        rst = 1'b0;
        #1;
        check("midrst_stallreq", 64'(stallreq_o), 0);
        check("midrst_hilo", {hi_o, lo_o}, 0);
        check("midrst_wreg", 64'(wreg_o), 0);
        check("midrst_ex_wreg", 64'(ex_wreg_o), 0);
        cyc;
        cyc;
        bubble;
        rst = 1'b1;
        repeat (3) cyc;
        check("postrst_hilo", {hi_o, lo_o}, 0);
        check("postrst_stallreq", 64'(stallreq_o), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
